wb_stage_mp: RTL and testbench

Multi-port, buffered write-back stage that sits between the memory stage and the register file. It accepts one retiring instruction per cycle from the MS stage into a DEPTH-entry in-order queue, and drains up to NPORT entries per cycle onto NPORT register-file write ports. Draining can be stalled by the register file. It exports a pending-write bitmask so decode can interlock on results still queued in WB.

---
 rtl/wb_stage_mp_pkg.sv | 29 ++
 rtl/wb_stage_mp_queue.sv | 74 +++++++
 rtl/wb_stage_mp.sv | 117 +++++++++++
 tb/tb_wb_stage_mp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_mp_pkg.sv
// wb_stage_mp_pkg: shared widths and record layouts for the multi-port
// write-back stage.
//   MS_TO_WS_BUS_WD : MS->WS bus width {pc, rf_we, rf_waddr, rf_wdata}
//   WB_RF_PORT_WD   : width of one register-file write port {we, waddr, wdata}
//   WB_NPORT        : default number of register-file write ports
package wb_stage_mp_pkg;

    localparam int unsigned MS_TO_WS_BUS_WD = 70;
    localparam int unsigned WB_RF_PORT_WD   = 38;
    localparam int unsigned WB_NPORT        = 2;

    // Position of the {we, waddr} tag inside a bus entry, used for hazard tracking.
    localparam int unsigned WB_TAG_LSB = 32;
    localparam int unsigned WB_TAG_WD  = 6;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } ms_ws_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_port_t;

endpackage

// File: rtl/wb_stage_mp_queue.sv
// wb_queue: generic DEPTH x WD in-order circular queue.
//   clk, reset     : clock, asynchronous active-high reset (pointers/count only)
//   push/push_data : write one entry at tail (caller guarantees !full)
//   pop_cnt        : number of entries (0..2) retired from head this cycle
//   rd0/rd1_data   : entries at head and head+1 (payload qualified by count)
//   count, full    : occupancy
//   slot_tag       : TAG_WD-bit field of every physical slot
//   slot_valid     : slot currently holds a live entry
module wb_queue
    import wb_stage_mp_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned WD      = MS_TO_WS_BUS_WD,
    parameter int unsigned TAG_LSB = WB_TAG_LSB,
    parameter int unsigned TAG_WD  = WB_TAG_WD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [WD-1:0]             push_data,
    input  logic [1:0]                pop_cnt,
    output logic [WD-1:0]             rd0_data,
    output logic [WD-1:0]             rd1_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic [DEPTH*TAG_WD-1:0]   slot_tag,
    output logic [DEPTH-1:0]          slot_valid
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WD-1:0] mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] offset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            head  <= head + AW'(pop_cnt);
            count <= count + (AW+1)'(push) - (AW+1)'(pop_cnt);
        end
    end

    // Payload has no reset; count alone says which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    assign rd0_data = mem[head];
    assign rd1_data = mem[head + AW'(1)];
    assign full     = (count == (AW+1)'(DEPTH));

    // A slot is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        slot_tag   = '0;
        slot_valid = '0;
        offset     = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            offset        = AW'(j) - head;
            slot_valid[j] = ({1'b0, offset} < count);
            slot_tag[j*TAG_WD +: TAG_WD] = mem[j][TAG_LSB +: TAG_WD];
        end
    end

endmodule

// File: rtl/wb_stage_mp.sv
// wb_stage_mp: buffered multi-port write-back stage between MS and the RF.
//   clk, reset                : clock, asynchronous active-high reset
//   ms_to_ws_valid/bus        : retiring instruction from MS
//   ws_allowin                : queue not full (independent of rf_stall)
//   rf_stall                  : RF refuses writes this cycle
//   ws_to_rf_bus              : NPORT x {we, waddr, wdata}, port 0 in LSBs
//   ws_valid                  : queue non-empty
//   ws_pend_vec               : registers with a queued write (bit 0 forced 0)
//   debug_wb_*                : port 0 trace (pc, we x4, waddr, wdata)
module wb_stage_mp
    import wb_stage_mp_pkg::*;
#(
    parameter int unsigned BUS_WD = MS_TO_WS_BUS_WD,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NPORT  = WB_NPORT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ms_to_ws_valid,
    input  logic [BUS_WD-1:0]             ms_to_ws_bus,
    output logic                          ws_allowin,
    input  logic                          rf_stall,
    output logic [NPORT*WB_RF_PORT_WD-1:0] ws_to_rf_bus,
    output logic                          ws_valid,
    output logic [31:0]                   ws_pend_vec,
    output logic [31:0]                   debug_wb_pc,
    output logic [3:0]                    debug_wb_rf_we,
    output logic [4:0]                    debug_wb_rf_waddr,
    output logic [31:0]                   debug_wb_rf_wdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic                          q_full;
    logic [AW:0]                   q_count;
    logic [BUS_WD-1:0]             q_rd0;
    logic [BUS_WD-1:0]             q_rd1;
    logic [DEPTH*WB_TAG_WD-1:0]    q_tag;
    logic [DEPTH-1:0]              q_slot_valid;
    logic                          push;
    logic [1:0]                    drain_cnt;
    logic                          same_addr;
    ms_ws_t                        e0;
    ms_ws_t                        e1;
    rf_port_t                      p0;
    logic                          unused_e1_pc;

    assign e0   = q_rd0;
    assign e1   = q_rd1;
    assign push = ms_to_ws_valid && ws_allowin;

    assign unused_e1_pc = ^e1.pc;

    wb_queue #(
        .DEPTH   (DEPTH),
        .WD      (BUS_WD),
        .TAG_LSB (WB_TAG_LSB),
        .TAG_WD  (WB_TAG_WD)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (ms_to_ws_bus),
        .pop_cnt    (drain_cnt),
        .rd0_data   (q_rd0),
        .rd1_data   (q_rd1),
        .count      (q_count),
        .full       (q_full),
        .slot_tag   (q_tag),
        .slot_valid (q_slot_valid)
    );

    assign ws_allowin = !q_full;
    assign ws_valid   = (q_count != '0);

    // Two writes to the same register in one cycle would lose ordering in
    // the RF, so the second one waits a cycle.
    always_comb begin
        drain_cnt = '0;
        same_addr = e0.we && e1.we && (e0.waddr == e1.waddr);
        if (!rf_stall && q_count != '0) begin
            if (NPORT >= 2 && q_count >= (AW+1)'(2) && !same_addr) begin
                drain_cnt = 2'd2;
            end else begin
                drain_cnt = 2'd1;
            end
        end
    end

    always_comb begin
        ws_to_rf_bus = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (i < 32'(drain_cnt)) begin
                ws_to_rf_bus[i*WB_RF_PORT_WD +: WB_RF_PORT_WD] =
                    (i == 0) ? e0[WB_RF_PORT_WD-1:0] : e1[WB_RF_PORT_WD-1:0];
            end
        end
    end

    // Entries still present (including ones draining now) keep their bit set.
    always_comb begin
        ws_pend_vec = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (q_slot_valid[j] && q_tag[j*WB_TAG_WD + 5]) begin
                ws_pend_vec[q_tag[j*WB_TAG_WD +: 5]] = 1'b1;
            end
        end
        ws_pend_vec[0] = 1'b0;
    end

    assign p0                = ws_to_rf_bus[WB_RF_PORT_WD-1:0];
    assign debug_wb_pc       = (drain_cnt != '0) ? e0.pc : '0;
    assign debug_wb_rf_we    = {4{p0.we}};
    assign debug_wb_rf_waddr = p0.waddr;
    assign debug_wb_rf_wdata = p0.wdata;

endmodule

// File: tb/tb_wb_stage_mp.sv
// tb_wb_stage_mp: scoreboard bench for wb_stage_mp (DEPTH=4, NPORT=2).
// The stimulus process keeps an abstract FIFO model and pushes the expected
// per-cycle outputs into a queue; the monitor pops and compares at negedge.
module tb_wb_stage_mp;

    localparam int DEPTH = 4;
    localparam int NPORT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ms_to_ws_valid = 1'b0;
    logic [69:0] ms_to_ws_bus = '0;
    logic        rf_stall = 1'b0;
    logic        ws_allowin;
    logic [75:0] ws_to_rf_bus;
    logic        ws_valid;
    logic [31:0] ws_pend_vec;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_waddr;
    logic [31:0] debug_wb_rf_wdata;

    wb_stage_mp #(
        .BUS_WD (70),
        .DEPTH  (DEPTH),
        .NPORT  (NPORT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allowin        (ws_allowin),
        .rf_stall          (rf_stall),
        .ws_to_rf_bus      (ws_to_rf_bus),
        .ws_valid          (ws_valid),
        .ws_pend_vec       (ws_pend_vec),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_waddr (debug_wb_rf_waddr),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } entry_t;

    typedef struct {
        logic        allowin;
        logic        valid;
        logic [31:0] pend;
        logic [75:0] ports;
        logic [31:0] pc;
        logic [3:0]  dwe;
        logic [4:0]  dwaddr;
        logic [31:0] dwdata;
    } exp_t;

    entry_t mq[$];
    exp_t   exp_q[$];
    int     checks = 0;
    int     failures = 0;

    int     prev_d = 0;
    bit     prev_enq = 0;
    bit     prev_rst = 1;
    entry_t prev_e;

    function automatic void chk(string name, logic [75:0] act, logic [75:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endfunction

    // One clock of stimulus: retire the model's view of the previous edge,
    // drive new inputs, and queue what the DUT must show this cycle.
    task automatic cycle(input bit v, input logic [31:0] pc, input bit we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input bit s, input bit r);
        exp_t   x;
        entry_t e;
        int     d;
        bit     same;
        @(posedge clk);
        #1;
        if (!prev_rst) begin
            for (int k = 0; k < prev_d; k++) mq.delete(0);
            if (prev_enq) mq.push_back(prev_e);
        end
        reset          = r;
        ms_to_ws_valid = v;
        ms_to_ws_bus   = {pc, we, wa, wd};
        rf_stall       = s;
        if (r) mq.delete();
        e = '{pc, we, wa, wd};

        d = 0;
        if (!r && !s && mq.size() > 0) begin
            same = (mq.size() >= 2) && mq[0].we && mq[1].we && (mq[0].waddr == mq[1].waddr);
            d = (mq.size() >= NPORT && !same) ? NPORT : 1;
        end

        x.allowin = (mq.size() != DEPTH);
        x.valid   = (mq.size() != 0);
        x.pend    = '0;
        foreach (mq[k]) if (mq[k].we) x.pend[mq[k].waddr] = 1'b1;
        x.pend[0] = 1'b0;
        x.ports   = '0;
        for (int i = 0; i < d; i++) x.ports[i*38 +: 38] = {mq[i].we, mq[i].waddr, mq[i].wdata};
        if (d > 0) begin
            x.pc     = mq[0].pc;
            x.dwe    = {4{mq[0].we}};
            x.dwaddr = mq[0].waddr;
            x.dwdata = mq[0].wdata;
        end else begin
            x.pc = '0; x.dwe = '0; x.dwaddr = '0; x.dwdata = '0;
        end

        prev_d   = d;
        prev_enq = !r && v && (mq.size() != DEPTH);
        prev_e   = e;
        prev_rst = r;
        exp_q.push_back(x);
    endtask

    task automatic idle(input bit s);
        cycle(0, '0, 0, '0, '0, s, 0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("ws_allowin", 76'(ws_allowin), 76'(x.allowin));
                chk("ws_valid",   76'(ws_valid),   76'(x.valid));
                chk("ws_pend_vec", 76'(ws_pend_vec), 76'(x.pend));
                chk("ws_to_rf_bus", ws_to_rf_bus, x.ports);
                chk("debug_wb_pc", 76'(debug_wb_pc), 76'(x.pc));
                chk("debug_wb_rf_we", 76'(debug_wb_rf_we), 76'(x.dwe));
                chk("debug_wb_rf_waddr", 76'(debug_wb_rf_waddr), 76'(x.dwaddr));
                chk("debug_wb_rf_wdata", 76'(debug_wb_rf_wdata), 76'(x.dwdata));
            end
        end
    end

    initial begin : stimulus
        // Reset held, then released.
        cycle(0, '0, 0, '0, '0, 0, 1);
        cycle(0, '0, 0, '0, '0, 0, 1);
        idle(0);

        // Single pass-through.
        cycle(1, 32'hBFC0_0000, 1, 5'd5, 32'h1234, 0, 0);
        idle(0); idle(0); idle(0);

        // Dual drain after a stall.
        cycle(1, 32'h100, 1, 5'd3, 32'hAAAA_0003, 1, 0);
        cycle(1, 32'h104, 1, 5'd4, 32'hAAAA_0004, 1, 0);
        idle(0); idle(0);

        // Same-address cap.
        cycle(1, 32'h200, 1, 5'd7, 32'hA, 1, 0);
        cycle(1, 32'h204, 1, 5'd7, 32'hB, 1, 0);
        idle(0); idle(0); idle(0);

        // Full queue, refused offer, then drain with valid held high.
        for (int i = 1; i <= 4; i++) cycle(1, 32'h300 + 4*i, 1, 5'(i), 32'h30 + i, 1, 0);
        cycle(1, 32'h3F0, 1, 5'd9, 32'hDEAD, 1, 0);
        cycle(1, 32'h3F4, 1, 5'd10, 32'hBEEF, 0, 0);
        cycle(1, 32'h3F8, 1, 5'd11, 32'hCAFE, 0, 0);
        idle(0); idle(0); idle(0); idle(0);

        // Wrap-around with alternating stall; includes we=0 and r0 writes.
        for (int i = 0; i < 9; i++)
            cycle(1, 32'h400 + 4*i, (i % 3) != 0, 5'(i % 5), 32'h4000 + i, i % 2, 0);
        for (int i = 0; i < 6; i++) idle(0);

        // Reset mid-run with three entries queued.
        for (int i = 0; i < 3; i++) cycle(1, 32'h500 + 4*i, 1, 5'(12 + i), 32'h500 + i, 1, 0);
        cycle(0, '0, 0, '0, '0, 0, 1);
        cycle(1, 32'h600, 1, 5'd20, 32'h600, 0, 0);
        idle(0); idle(0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 6; i++) idle(0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
